// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial pattern transmitter and its golden match model.
package seq_pkg;

  // Transmitter control states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH   = 28;
  localparam int unsigned DEF_PAT_LEN = 3;
  localparam int unsigned MAX_PAT_LEN = 8;
  localparam logic [MAX_PAT_LEN-1:0] DEF_PATTERN = 8'b0000_0101;

  // Width of a length field able to hold 0..width
  function automatic int unsigned len_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_match_model.sv
// Golden overlapping sequence detector: flags each valid bit that completes PATTERN.
// History and fill count persist across gaps in valid; only reset clears them.
module seq_match_model
  import seq_pkg::*;
#(
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_i,
  input  logic valid_i,
  output logic exp_f_o
);

  // A 1-bit history keeps the vectors legal when PAT_LEN is 1; its content is then unused.
  localparam int unsigned HW = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
  localparam int unsigned CW = $clog2(PAT_LEN + 1);

  logic [HW-1:0] hist_q, hist_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          exp_f_q, exp_f_d;
  logic [HW:0]   window;
  logic          primed;

  // Evaluate the match on the incoming bit and advance history
  always_comb begin
    window  = {hist_q, bit_i};
    primed  = (32'(cnt_q) + 32'd1) >= PAT_LEN;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    exp_f_d = 1'b0;
    if (valid_i) begin
      exp_f_d = primed && (window[PAT_LEN-1:0] == PATTERN);
      hist_d  = window[HW-1:0];
      if (32'(cnt_q) < PAT_LEN) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // History, saturating fill count and registered flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q  <= '0;
      cnt_q   <= '0;
      exp_f_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      exp_f_q <= exp_f_d;
    end
  end

  assign exp_f_o = exp_f_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial stimulus transmitter: shifts loaded words out MSB-first with a registered
// valid, a last-bit DONE pulse and the flag a correct detector must raise per bit.
module serial_pattern_tx
  import seq_pkg::*;
#(
  parameter int unsigned        WIDTH   = DEF_WIDTH,
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         LOAD_VALID,
  output logic                         LOAD_READY,
  input  logic [WIDTH-1:0]             LOAD_DATA,
  input  logic [len_width(WIDTH)-1:0]  LOAD_LEN,
  output logic                         X,
  output logic                         X_VALID,
  output logic                         EXP_F,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int unsigned LW = len_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LW-1:0]    rem_q, rem_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             accept;
  logic             go_load;
  logic             go_shift;
  logic [LW-1:0]    len_eff;

  // Next-state, shifter and output decode; rem counts bits still to show including the current one
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    rem_d    = rem_q;
    x_d      = 1'b0;
    xv_d     = 1'b0;
    done_d   = 1'b0;
    go_load  = 1'b0;
    go_shift = 1'b0;

    accept  = LOAD_VALID && ready_q;
    len_eff = ((LOAD_LEN == '0) || (32'(LOAD_LEN) > WIDTH)) ? LW'(WIDTH) : LOAD_LEN;

    case (state_q)
      ST_IDLE: begin
        go_load = accept;
      end
      ST_SHIFT: begin
        if (rem_q == LW'(1)) begin
          if (accept) begin
            go_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end
        end else begin
          go_shift = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = '0;
      end
    endcase

    if (go_load) begin
      state_d = ST_SHIFT;
      x_d     = LOAD_DATA[WIDTH-1];
      xv_d    = 1'b1;
      shreg_d = {LOAD_DATA[WIDTH-2:0], 1'b0};
      rem_d   = len_eff;
      done_d  = (len_eff == LW'(1));
    end else if (go_shift) begin
      x_d     = shreg_q[WIDTH-1];
      xv_d    = 1'b1;
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      rem_d   = rem_q - LW'(1);
      done_d  = (rem_q == LW'(2));
    end

    busy_d  = (state_d == ST_SHIFT);
    ready_d = (state_d == ST_IDLE) || (rem_d == LW'(1));
  end

  // State, shifter and registered outputs; reset aborts any word in flight
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Reference detector fed with the bit being registered this edge, so EXP_F lines up with X
  seq_match_model #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_match (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .bit_i   (x_d),
    .valid_i (xv_d),
    .exp_f_o (EXP_F)
  );

  assign X          = x_q;
  assign X_VALID    = xv_q;
  assign DONE       = done_q;
  assign BUSY       = busy_q;
  assign LOAD_READY = ready_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: schedules words on the load port and compares every
// cycle against a queue-based model of the expected stream and match flags.
module tb_serial_pattern_tx;

  localparam int W  = 28;
  localparam int LW = 5;
  localparam int PL = 3;
  localparam logic [2:0] PAT = 3'b101;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          LOAD_VALID = 1'b0;
  logic          LOAD_READY;
  logic [W-1:0]  LOAD_DATA = '0;
  logic [LW-1:0] LOAD_LEN = '0;
  logic          X, X_VALID, EXP_F, BUSY, DONE;

  serial_pattern_tx dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LOAD_VALID (LOAD_VALID),
    .LOAD_READY (LOAD_READY),
    .LOAD_DATA  (LOAD_DATA),
    .LOAD_LEN   (LOAD_LEN),
    .X          (X),
    .X_VALID    (X_VALID),
    .EXP_F      (EXP_F),
    .BUSY       (BUSY),
    .DONE       (DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] data;
    int           len;
    int           start;
  } word_t;

  word_t      sched[$];
  logic [5:0] obs[$];
  logic [5:0] exp_q[$];
  bit         hist[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Sliding window of emitted bits; flag when the last PL bits spell the pattern
  function automatic bit model_push(input bit b);
    hist.push_back(b);
    if (hist.size() > PL) void'(hist.pop_front());
    if (hist.size() < PL) return 1'b0;
    for (int i = 0; i < PL; i++) begin
      if (hist[i] != PAT[PL-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int eff_len(input int len);
    return (len == 0 || len > W) ? W : len;
  endfunction

  // Expected per-cycle {ready, busy, valid, x, flag, done} from the word schedule
  task automatic build_expected(input int ncyc);
    bit xv[];
    bit xb[];
    bit dn[];
    int last_end;
    int a;
    int n;
    word_t w;
    bit f;
    xv = new[ncyc];
    xb = new[ncyc];
    dn = new[ncyc];
    last_end = 0;
    for (int i = 0; i < sched.size(); i++) begin
      w = sched[i];
      n = eff_len(w.len);
      a = (w.start > last_end) ? w.start : last_end;
      for (int k = 0; k < n; k++) begin
        if (a + 1 + k < ncyc) begin
          xv[a+1+k] = 1'b1;
          xb[a+1+k] = w.data[W-1-k];
          dn[a+1+k] = (k == n - 1);
        end
      end
      last_end = a + n;
    end
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      f = xv[c] ? model_push(xb[c]) : 1'b0;
      exp_q.push_back({(!xv[c]) || dn[c], xv[c], xv[c], xb[c], f, dn[c]});
    end
  endtask

  // Drive the schedule for ncyc cycles, sampling outputs at each falling edge
  task automatic run_sched(input int ncyc, output int left);
    word_t pend[$];
    pend = sched;
    obs.delete();
    for (int c = 0; c < ncyc; c++) begin
      obs.push_back({LOAD_READY, BUSY, X_VALID, X, EXP_F, DONE});
      if (pend.size() > 0 && c >= pend[0].start) begin
        LOAD_VALID = 1'b1;
        LOAD_DATA  = pend[0].data;
        LOAD_LEN   = LW'(pend[0].len);
      end else begin
        LOAD_VALID = 1'b0;
        LOAD_DATA  = W'($urandom);
        LOAD_LEN   = LW'($urandom);
      end
      if (LOAD_VALID && LOAD_READY) void'(pend.pop_front());
      @(negedge CLK);
    end
    LOAD_VALID = 1'b0;
    left = pend.size();
  endtask

  task automatic test_reset();
    int left;
    RST_N = 1'b0;
    LOAD_VALID = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      n_checks++;
      if ({X_VALID, X, EXP_F, DONE, BUSY} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got valid/x/f/done/busy=%b expected 00000",
                 {X_VALID, X, EXP_F, DONE, BUSY});
      end
    end
    RST_N = 1'b1;
    hist.delete();
    sched.delete();
    run_sched(6, left);
    build_expected(6);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_word();
    int left;
    sched.delete();
    sched.push_back('{28'h2A959A8, 28, 0});
    run_sched(31, left);
    build_expected(31);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL single_word_accept: %0d words left, expected 0", left);
    end
    for (int i = 0; i < 31; i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_word cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_short_len();
    int left;
    sched.delete();
    sched.push_back('{28'hA000000, 4, 0});
    sched.push_back('{W'($urandom), 0, 7});
    sched.push_back('{W'($urandom), 29, 40});
    run_sched(72, left);
    build_expected(72);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL short_len_accept: %0d words left, expected 0", left);
    end
    for (int i = 0; i < 72; i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL short_len cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int left;
    sched.delete();
    sched.push_back('{28'hA000000, 2, 0});
    sched.push_back('{28'h8000000, 1, 0});
    run_sched(6, left);
    build_expected(6);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL back_to_back_accept: %0d words left, expected 0", left);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int left;
    sched.delete();
    sched.push_back('{W'($urandom), 28, 0});
    sched.push_back('{W'($urandom), 12, 5});
    run_sched(44, left);
    build_expected(44);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL backpressure_accept: %0d words left, expected 0", left);
    end
    for (int i = 0; i < 44; i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL backpressure cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int left;
    sched.delete();
    sched.push_back('{28'h2A959A8, 28, 0});
    run_sched(11, left);
    build_expected(11);
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_word_pre cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b", i, obs[i], exp_q[i]);
      end
    end
    // Bit index 10 is on the wire now; abort it asynchronously
    RST_N = 1'b0;
    #1;
    for (int r = 0; r < 3; r++) begin
      n_checks++;
      if ({X_VALID, X, EXP_F, DONE, BUSY} !== 5'b0) begin
        n_fail++;
        $display("FAIL mid_word_reset step %0d: got valid/x/f/done/busy=%b expected 00000",
                 r, {X_VALID, X, EXP_F, DONE, BUSY});
      end
      @(negedge CLK);
    end
    RST_N = 1'b1;
    hist.delete();
    sched.delete();
    sched.push_back('{28'hA000000, 3, 0});
    run_sched(6, left);
    build_expected(6);
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL mid_word_reload_accept: %0d words left, expected 0", left);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (obs[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL mid_word_reload cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b", i, obs[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int left;
    int st;
    int ncyc;
    for (int rep = 0; rep < 3; rep++) begin
      sched.delete();
      st = 0;
      ncyc = 4;
      for (int j = 0; j < 8; j++) begin
        st += $urandom_range(0, 40);
        sched.push_back('{W'($urandom), $urandom_range(0, 31), st});
        ncyc += eff_len(sched[j].len);
      end
      ncyc += st;
      run_sched(ncyc, left);
      build_expected(ncyc);
      n_checks++;
      if (left != 0) begin
        n_fail++;
        $display("FAIL random_accept rep %0d: %0d words left, expected 0", rep, left);
      end
      for (int i = 0; i < ncyc; i++) begin
        n_checks++;
        if (obs[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random rep %0d cycle %0d: got rdy/busy/xv/x/f/done=%b expected %b",
                   rep, i, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_short_len();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial stimulus transmitter: the sending end of the single-bit serial stream consumed by the lab sequence detectors.
- Accepts a parallel word over a valid/ready load port and shifts it out MSB-first, one bit per CLK, on X with a qualifying X_VALID.
- Runs a golden overlapping-match model alongside the shifter and emits EXP_F, the flag a correct detector must raise for the same bit. Benches use it as both stimulus source and scoreboard reference.

Parameters:
- WIDTH, 28, maximum bits per load word.
- PAT_LEN, 3, length of the target sequence, 1..8.
- PATTERN, 3'b101, target sequence; its MSB is the earliest bit on the wire.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- LOAD_VALID  in  1  load request.
- LOAD_READY  out  1  block can accept a load this cycle.
- LOAD_DATA  in  WIDTH  word to send; bit WIDTH-1 goes out first.
- LOAD_LEN  in  $clog2(WIDTH+1)  number of bits to send; 0 or >WIDTH means WIDTH.
- X  out  1  serial data bit.
- X_VALID  out  1  X carries a real bit this cycle.
- EXP_F  out  1  expected detector flag for the current X.
- BUSY  out  1  shifting in progress.
- DONE  out  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Reset (async, RST_N low): state IDLE; X=0, X_VALID=0, EXP_F=0, BUSY=0, DONE=0; shift register, bit counter and match history cleared; LOAD_READY=1 once RST_N is high.
- FSM states:
  - IDLE, BUSY=0: an accept moves the block to SHIFT.
  - SHIFT, BUSY=1: emits one bit per cycle.
  - On the last bit, either go to IDLE, or stay in SHIFT when a new load is accepted that same cycle.
- Accept occurs on a rising edge with LOAD_VALID && LOAD_READY.
- LOAD_READY = (state==IDLE) || (state==SHIFT && remaining==1). The second term gives back-to-back words with no gap bit.
- Latency: the first bit, LOAD_DATA[WIDTH-1], appears on X with X_VALID=1 in the cycle after the accept edge. Bit k appears k cycles later, for k = 0..N-1 where N is the effective length.
- X, X_VALID, EXP_F and DONE are all registered and change together.
- When X_VALID=0, X is held at 0.
- DONE=1 exactly with bit N-1. DONE does not assert when no word is loaded.
- LOAD_DATA and LOAD_LEN are sampled only at accept. Input changes during SHIFT are ignored.
- Match model:
  - hist holds the last PAT_LEN-1 emitted bits; cnt saturates at PAT_LEN.
  - On each emitted bit b: EXP_F = (cnt >= PAT_LEN-1) && ({hist,b} == PATTERN); then hist shifts in b and cnt increments.
  - Overlapping matches count.
  - hist and cnt persist across word boundaries and idle gaps; only reset clears them.
  - EXP_F=0 whenever X_VALID=0.
- A load request while BUSY, other than in the final-bit cycle, is held off (LOAD_READY=0) and is not lost.
- RST_N asserted mid-word aborts immediately. No DONE is produced, and history is cleared.
- PAT_LEN=1: EXP_F = (b == PATTERN[0]) for every valid bit.

Decomposition:
- Shared package `seq_pkg`: state encoding constants (IDLE, SHIFT), default PATTERN/PAT_LEN, and the length-width function.
- One natural sub-module: `seq_match_model`, which takes the bit and its valid and produces EXP_F. It holds hist and cnt, and is reusable as a standalone golden detector in other lab benches.

Test Plan:
- Reset then idle: RST_N=0 for 3 cycles, then high with no load -> X_VALID=0, EXP_F=0, DONE=0, LOAD_READY=1 throughout.
- Single word: load 28'h2A959A8, LEN=28 -> X sequence 0010101010010101100110101000 starting the cycle after accept. EXP_F=1 on bit indices 4, 6, 8, 13, 15, 22, 24 only. DONE on index 27, then BUSY=0.
- Short length: LOAD_DATA=28'hA000000, LEN=4 -> X=1,0,1,0. EXP_F=1 on index 2 only. DONE on index 3. LEN=0 -> 28 bits sent.
- Back-to-back: LOAD_VALID held high with words 28'hA000000 (LEN=2, bits "10") then 28'h8000000 (LEN=1, bit "1") -> X_VALID continuous for 3 cycles, no gap. EXP_F=1 on the third bit (match spans the word boundary). DONE pulses on bits 1 and 2.
- Backpressure: LOAD_VALID asserted mid-word -> LOAD_READY=0 until the final-bit cycle. The new word starts exactly one cycle after the old one's DONE, with no bits dropped.
- Reset mid-word: RST_N low at bit 10 of the 28-bit vector -> outputs go to 0 at once with no DONE. Reloading "101" afterwards -> EXP_F=1 only on its third bit, because history was cleared.
